// File: rtl/ifetch_req_ctrl.sv
`timescale 1ns/1ps
// Pre-IF fetch sequencer: owns the instruction bus, one request in flight, drops stale returns on redirect.
// Latency: addr_ok in T, data_ok in T+1 -> to_if_valid in T+2; holds the instruction while IF stalls.
module ifetch_req_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_allow_in,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        to_if_valid,
    output logic [31:0] to_if_pc,
    output logic [31:0] to_if_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            req_pc_q   <= PC_RESET;
            next_pc_q  <= PC_RESET;
            discard_q  <= 1'b0;
            out_pc_q   <= 32'd0;
            out_inst_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            next_pc_q  <= next_pc_d;
            discard_q  <= discard_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        next_pc_d  = next_pc_q;
        discard_d  = discard_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;

        case (state_q)
            S_REQ: begin
                // req_pc stays on the bus until accepted; a redirect only retargets what follows
                if (inst_sram_addr_ok) begin
                    state_d = S_WAIT;
                    if (redirect_valid) begin
                        next_pc_d = redirect_pc;
                        discard_d = 1'b1;
                    end else if (!discard_q) begin
                        next_pc_d = req_pc_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    next_pc_d = redirect_pc;
                    discard_d = 1'b1;
                end
            end

            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (discard_q || redirect_valid) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                        if (redirect_valid) begin
                            req_pc_d  = redirect_pc;
                            next_pc_d = redirect_pc;
                        end else begin
                            req_pc_d = next_pc_q;
                        end
                    end else begin
                        out_pc_d   = req_pc_q;
                        out_inst_d = inst_sram_rdata;
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    next_pc_d = redirect_pc;
                    discard_d = 1'b1;
                end
            end

            S_HOLD: begin
                // the buffered word is younger than any redirecting instruction, so redirect wins
                if (redirect_valid) begin
                    req_pc_d  = redirect_pc;
                    next_pc_d = redirect_pc;
                    state_d   = S_REQ;
                end else if (if_allow_in) begin
                    req_pc_d = next_pc_q;
                    state_d  = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign inst_sram_req  = (state_q == S_REQ) && !rst;
    assign inst_sram_addr = req_pc_q;
    assign to_if_valid    = (state_q == S_HOLD) && !redirect_valid;
    assign to_if_pc       = out_pc_q;
    assign to_if_inst     = out_inst_q;

endmodule
